// File: rtl/rfdc_wb_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rfdc_arb_pkg : shared types and default widths for rfdc_wb_arbiter   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package rfdc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    RESP_ACK = 1'b0,
    RESP_ERR = 1'b1
  } resp_t;

  localparam int DEF_ADR_BITS = 18;
  localparam int DEF_DAT_BITS = 32;

endpackage
`default_nettype wire

// File: rtl/rfdc_wb_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rfdc_wb_arbiter_if : requester-side and converter-side WB signals    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface rfdc_wb_arbiter_if
  import rfdc_arb_pkg::*;
#(
  parameter int NMASTER  = 3,
  parameter int ADR_BITS = DEF_ADR_BITS,
  parameter int DAT_BITS = DEF_DAT_BITS
);
  localparam int c_SEL_BITS = DAT_BITS / 8;
  localparam int c_GW       = $clog2(NMASTER);

  logic [NMASTER-1:0]            m_cyc_i;
  logic [NMASTER-1:0]            m_stb_i;
  logic [NMASTER-1:0]            m_we_i;
  logic [NMASTER*ADR_BITS-1:0]   m_adr_i;
  logic [NMASTER*DAT_BITS-1:0]   m_dat_i;
  logic [NMASTER*c_SEL_BITS-1:0] m_sel_i;
  logic [NMASTER-1:0]            m_ack_o;
  logic [NMASTER-1:0]            m_err_o;
  logic [DAT_BITS-1:0]           m_dat_o;

  logic                          s_cyc_o;
  logic                          s_stb_o;
  logic                          s_we_o;
  logic [ADR_BITS-1:0]           s_adr_o;
  logic [DAT_BITS-1:0]           s_dat_o;
  logic [c_SEL_BITS-1:0]         s_sel_o;
  logic                          s_ack_i;
  logic                          s_err_i;
  logic [DAT_BITS-1:0]           s_dat_i;

  logic [c_GW-1:0]               grant_o;
  logic                          busy_o;
  logic                          timeout_o;

  // Arbiter's own view of the whole bundle
  modport arb (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
    output m_ack_o, m_err_o, m_dat_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    input  s_ack_i, s_err_i, s_dat_i,
    output grant_o, busy_o, timeout_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
    input  m_ack_o, m_err_o, m_dat_o
  );

  modport slave (
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    output s_ack_i, s_err_i, s_dat_i
  );

endinterface
`default_nettype wire

// File: rtl/rfdc_wb_arbiter_rr_prio_sel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_prio_sel : picks the first requester after i_last, wrapping       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_prio_sel
  import rfdc_arb_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_last,
  output logic                 o_valid,
  output logic [$clog2(N)-1:0] o_idx
);
  localparam int c_IW = $clog2(N);

  // Scan from the farthest offset down so the nearest requester wins last
  always_comb begin
    int w_cand;
    w_cand  = 0;
    o_valid = 1'b0;
    o_idx   = '0;
    for (int i = N; i >= 1; i--) begin
      w_cand = (int'(i_last) + i) % N;
      if (i_req[w_cand[c_IW-1:0]]) begin
        o_valid = 1'b1;
        o_idx   = w_cand[c_IW-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rfdc_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rfdc_wb_arbiter : round-robin share of the converter WB port         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rfdc_wb_arbiter
  import rfdc_arb_pkg::*;
#(
  parameter int NMASTER  = 3,
  parameter int ADR_BITS = DEF_ADR_BITS,
  parameter int DAT_BITS = DEF_DAT_BITS,
  parameter int TIMEOUT  = 1024
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  rfdc_wb_arbiter_if.arb bus
);
  localparam int              c_SEL_BITS = DAT_BITS / 8;
  localparam int              c_GW       = $clog2(NMASTER);
  localparam int              c_CW       = $clog2(TIMEOUT + 1);
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(TIMEOUT - 1);

  state_t                r_state;
  logic [c_GW-1:0]       r_grant;
  logic [c_GW-1:0]       r_last;
  logic [ADR_BITS-1:0]   r_adr;
  logic [DAT_BITS-1:0]   r_dat;
  logic [c_SEL_BITS-1:0] r_sel;
  logic                  r_we;
  logic [DAT_BITS-1:0]   r_rdata;
  logic [c_CW-1:0]       r_cnt;
  logic [NMASTER-1:0]    r_ack;
  logic [NMASTER-1:0]    r_err;
  logic                  r_timeout;

  logic [NMASTER-1:0]    w_req;
  logic                  w_valid;
  logic [c_GW-1:0]       w_idx;
  logic                  w_expire;
  logic                  w_term;
  resp_t                 w_resp;

  assign w_req = bus.m_cyc_i & bus.m_stb_i;

  rr_prio_sel #(.N(NMASTER)) u_sel (
    .i_req   (w_req),
    .i_last  (r_last),
    .o_valid (w_valid),
    .o_idx   (w_idx)
  );

  assign w_expire = (r_cnt == c_CNT_LAST);
  assign w_term   = bus.s_ack_i | bus.s_err_i | w_expire;
  // Error takes precedence over ack; expiry without ack is an error too
  assign w_resp   = (bus.s_err_i || !bus.s_ack_i) ? RESP_ERR : RESP_ACK;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_last    <= c_GW'(NMASTER - 1);
      r_adr     <= '0;
      r_dat     <= '0;
      r_sel     <= '0;
      r_we      <= 1'b0;
      r_rdata   <= '0;
      r_cnt     <= '0;
      r_ack     <= '0;
      r_err     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_ack     <= '0;
      r_err     <= '0;
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_grant <= w_idx;
            r_adr   <= bus.m_adr_i[int'(w_idx)*ADR_BITS +: ADR_BITS];
            r_dat   <= bus.m_dat_i[int'(w_idx)*DAT_BITS +: DAT_BITS];
            r_sel   <= bus.m_sel_i[int'(w_idx)*c_SEL_BITS +: c_SEL_BITS];
            r_we    <= bus.m_we_i[w_idx];
            r_state <= BUSY;
          end
        end
        BUSY: begin
          r_cnt <= r_cnt + c_CW'(1);
          if (bus.s_ack_i) r_rdata <= bus.s_dat_i;
          if (w_term) begin
            r_ack[r_grant] <= (w_resp == RESP_ACK);
            r_err[r_grant] <= (w_resp == RESP_ERR);
            r_timeout      <= w_expire && !bus.s_ack_i && !bus.s_err_i;
            r_state        <= DONE;
          end
        end
        DONE: begin
          r_last  <= r_grant;
          r_cnt   <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.s_cyc_o   = (r_state == BUSY);
  assign bus.s_stb_o   = (r_state == BUSY);
  assign bus.s_we_o    = r_we;
  assign bus.s_adr_o   = r_adr;
  assign bus.s_dat_o   = r_dat;
  assign bus.s_sel_o   = r_sel;
  assign bus.m_ack_o   = r_ack;
  assign bus.m_err_o   = r_err;
  assign bus.m_dat_o   = r_rdata;
  assign bus.grant_o   = r_grant;
  assign bus.busy_o    = (r_state != IDLE);
  assign bus.timeout_o = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rfdc_wb_arbiter.sv
`default_nettype none
// Directed bench for rfdc_wb_arbiter: 3 masters, TIMEOUT=16.
module tb_rfdc_wb_arbiter;
  localparam int NM = 3;
  localparam int AB = 18;
  localparam int DB = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [AB-1:0] adr_tab [NM] = '{18'h00100, 18'h2A5A5, 18'h3FFFC};

  always #5 clk = ~clk;

  rfdc_wb_arbiter_if #(.NMASTER(NM), .ADR_BITS(AB), .DAT_BITS(DB)) bus ();

  rfdc_wb_arbiter #(.NMASTER(NM), .ADR_BITS(AB), .DAT_BITS(DB), .TIMEOUT(TO)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int k, input logic req, input logic we,
                       input logic [DB-1:0] dat, input logic [3:0] sel);
    bus.m_cyc_i[k]        = req;
    bus.m_stb_i[k]        = req;
    bus.m_we_i[k]         = we;
    bus.m_adr_i[k*AB +: AB] = adr_tab[k];
    bus.m_dat_i[k*DB +: DB] = dat;
    bus.m_sel_i[k*4 +: 4]   = sel;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (bus.s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL rst_scyc got=%b exp=0", bus.s_cyc_o); end
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", bus.busy_o); end
    n_checks++; if (bus.grant_o !== 2'd0) begin n_fail++; $display("FAIL rst_grant got=%0d exp=0", bus.grant_o); end
    n_checks++; if ({bus.m_ack_o, bus.m_err_o, bus.timeout_o} !== 7'b0) begin n_fail++; $display("FAIL rst_resp got=%b exp=0", {bus.m_ack_o, bus.m_err_o, bus.timeout_o}); end
    n_checks++; if (bus.s_adr_o !== 18'h0) begin n_fail++; $display("FAIL rst_adr got=%h exp=0", bus.s_adr_o); end
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    set_m(1, 1'b1, 1'b0, 32'h0, 4'hF);
    tick();
    n_checks++; if (bus.s_cyc_o !== 1'b1 || bus.s_stb_o !== 1'b1) begin n_fail++; $display("FAIL rd_scyc got=%b%b exp=11", bus.s_cyc_o, bus.s_stb_o); end
    n_checks++; if (bus.s_adr_o !== adr_tab[1]) begin n_fail++; $display("FAIL rd_adr got=%h exp=%h", bus.s_adr_o, adr_tab[1]); end
    n_checks++; if (bus.grant_o !== 2'd1) begin n_fail++; $display("FAIL rd_grant got=%0d exp=1", bus.grant_o); end
    n_checks++; if (bus.s_we_o !== 1'b0) begin n_fail++; $display("FAIL rd_we got=%b exp=0", bus.s_we_o); end
    for (int i = 0; i < 4; i++) tick();
    n_checks++; if (bus.s_cyc_o !== 1'b1 || bus.m_ack_o !== 3'b000) begin n_fail++; $display("FAIL rd_wait got=%b/%b exp=1/000", bus.s_cyc_o, bus.m_ack_o); end
    bus.s_ack_i = 1'b1;
    bus.s_dat_i = 32'hDEADBEEF;
    tick();
    bus.s_ack_i = 1'b0;
    bus.s_dat_i = 32'h0;
    set_m(1, 1'b0, 1'b0, 32'h0, 4'h0);
    n_checks++; if (bus.m_ack_o !== 3'b010) begin n_fail++; $display("FAIL rd_ack got=%b exp=010", bus.m_ack_o); end
    n_checks++; if (bus.m_dat_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data got=%h exp=deadbeef", bus.m_dat_o); end
    n_checks++; if (bus.s_cyc_o !== 1'b0 || bus.m_err_o !== 3'b000) begin n_fail++; $display("FAIL rd_done got=%b/%b exp=0/000", bus.s_cyc_o, bus.m_err_o); end
    tick();
    n_checks++; if (bus.m_ack_o !== 3'b000 || bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL rd_pulse got=%b/%b exp=000/0", bus.m_ack_o, bus.busy_o); end
  endtask

  task automatic test_round_robin();
    int exp_g;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < NM; k++) set_m(k, 1'b1, 1'b0, 32'h0, 4'hF);
    for (int t = 0; t < 9; t++) begin
      exp_g = t % NM;
      tick();
      n_checks++; if (bus.grant_o !== 2'(exp_g) || bus.s_cyc_o !== 1'b1) begin n_fail++; $display("FAIL rr_grant[%0d] got=%0d/%b exp=%0d/1", t, bus.grant_o, bus.s_cyc_o, exp_g); end
      n_checks++; if (bus.s_adr_o !== adr_tab[exp_g]) begin n_fail++; $display("FAIL rr_adr[%0d] got=%h exp=%h", t, bus.s_adr_o, adr_tab[exp_g]); end
      bus.s_ack_i = 1'b1;
      tick();
      bus.s_ack_i = 1'b0;
      n_checks++; if (bus.m_ack_o !== 3'(1 << exp_g)) begin n_fail++; $display("FAIL rr_ack[%0d] got=%b exp=%b", t, bus.m_ack_o, 3'(1 << exp_g)); end
      tick();
      n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL rr_idle[%0d] got=%b exp=0", t, bus.busy_o); end
    end
    for (int k = 0; k < NM; k++) set_m(k, 1'b0, 1'b0, 32'h0, 4'h0);
  endtask

  task automatic test_timeout();
    set_m(0, 1'b1, 1'b1, 32'h12345678, 4'b0011);
    tick();
    n_checks++; if (bus.s_we_o !== 1'b1 || bus.s_sel_o !== 4'b0011 || bus.s_dat_o !== 32'h12345678) begin n_fail++; $display("FAIL to_wr got=%b/%b/%h exp=1/0011/12345678", bus.s_we_o, bus.s_sel_o, bus.s_dat_o); end
    for (int c = 2; c <= TO; c++) begin
      tick();
      n_checks++; if (bus.s_cyc_o !== 1'b1 || bus.timeout_o !== 1'b0 || bus.m_err_o !== 3'b000) begin n_fail++; $display("FAIL to_hold[%0d] got=%b/%b/%b exp=1/0/000", c, bus.s_cyc_o, bus.timeout_o, bus.m_err_o); end
    end
    tick();
    n_checks++; if (bus.timeout_o !== 1'b1 || bus.m_err_o !== 3'b001 || bus.m_ack_o !== 3'b000) begin n_fail++; $display("FAIL to_fire got=%b/%b/%b exp=1/001/000", bus.timeout_o, bus.m_err_o, bus.m_ack_o); end
    n_checks++; if (bus.s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL to_scyc got=%b exp=0", bus.s_cyc_o); end
    set_m(0, 1'b0, 1'b0, 32'h0, 4'h0);
    bus.s_ack_i = 1'b1;
    tick();
    tick();
    n_checks++; if (bus.m_ack_o !== 3'b000 || bus.timeout_o !== 1'b0 || bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL to_late got=%b/%b/%b exp=000/0/0", bus.m_ack_o, bus.timeout_o, bus.busy_o); end
    bus.s_ack_i = 1'b0;
  endtask

  task automatic test_ack_err_same();
    set_m(2, 1'b1, 1'b0, 32'h0, 4'hF);
    tick();
    n_checks++; if (bus.grant_o !== 2'd2) begin n_fail++; $display("FAIL ae_grant got=%0d exp=2", bus.grant_o); end
    bus.s_ack_i = 1'b1;
    bus.s_err_i = 1'b1;
    tick();
    bus.s_ack_i = 1'b0;
    bus.s_err_i = 1'b0;
    set_m(2, 1'b0, 1'b0, 32'h0, 4'h0);
    n_checks++; if (bus.m_err_o !== 3'b100 || bus.m_ack_o !== 3'b000) begin n_fail++; $display("FAIL ae_resp got=%b/%b exp=100/000", bus.m_err_o, bus.m_ack_o); end
    n_checks++; if (bus.timeout_o !== 1'b0) begin n_fail++; $display("FAIL ae_to got=%b exp=0", bus.timeout_o); end
    tick();
  endtask

  task automatic test_master_abort();
    set_m(1, 1'b1, 1'b0, 32'h0, 4'hF);
    set_m(2, 1'b1, 1'b0, 32'h0, 4'hF);
    tick();
    n_checks++; if (bus.grant_o !== 2'd1) begin n_fail++; $display("FAIL ab_grant got=%0d exp=1", bus.grant_o); end
    set_m(1, 1'b0, 1'b0, 32'h0, 4'h0);
    tick();
    tick();
    n_checks++; if (bus.s_cyc_o !== 1'b1) begin n_fail++; $display("FAIL ab_hold got=%b exp=1", bus.s_cyc_o); end
    bus.s_ack_i = 1'b1;
    tick();
    bus.s_ack_i = 1'b0;
    n_checks++; if (bus.m_ack_o !== 3'b010) begin n_fail++; $display("FAIL ab_ack got=%b exp=010", bus.m_ack_o); end
    tick();
    tick();
    n_checks++; if (bus.grant_o !== 2'd2 || bus.s_cyc_o !== 1'b1) begin n_fail++; $display("FAIL ab_next got=%0d/%b exp=2/1", bus.grant_o, bus.s_cyc_o); end
    set_m(2, 1'b0, 1'b0, 32'h0, 4'h0);
    bus.s_ack_i = 1'b1;
    tick();
    bus.s_ack_i = 1'b0;
    tick();
  endtask

  task automatic test_mid_reset();
    set_m(1, 1'b1, 1'b0, 32'h0, 4'hF);
    tick();
    n_checks++; if (bus.s_cyc_o !== 1'b1 || bus.grant_o !== 2'd1) begin n_fail++; $display("FAIL mr_busy got=%b/%0d exp=1/1", bus.s_cyc_o, bus.grant_o); end
    rst = 1'b1;
    bus.s_ack_i = 1'b1;
    tick();
    rst = 1'b0;
    bus.s_ack_i = 1'b0;
    n_checks++; if (bus.s_cyc_o !== 1'b0 || bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL mr_idle got=%b/%b exp=0/0", bus.s_cyc_o, bus.busy_o); end
    n_checks++; if (bus.m_ack_o !== 3'b000 || bus.m_err_o !== 3'b000) begin n_fail++; $display("FAIL mr_resp got=%b/%b exp=000/000", bus.m_ack_o, bus.m_err_o); end
    for (int k = 0; k < NM; k++) set_m(k, 1'b1, 1'b0, 32'h0, 4'hF);
    tick();
    n_checks++; if (bus.grant_o !== 2'd0 || bus.s_cyc_o !== 1'b1) begin n_fail++; $display("FAIL mr_first got=%0d/%b exp=0/1", bus.grant_o, bus.s_cyc_o); end
    n_checks++; if (bus.m_ack_o !== 3'b000) begin n_fail++; $display("FAIL mr_noack got=%b exp=000", bus.m_ack_o); end
    for (int k = 0; k < NM; k++) set_m(k, 1'b0, 1'b0, 32'h0, 4'h0);
    bus.s_ack_i = 1'b1;
    tick();
    bus.s_ack_i = 1'b0;
    tick();
  endtask

  initial begin
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    bus.m_we_i  = '0;
    bus.m_adr_i = '0;
    bus.m_dat_i = '0;
    bus.m_sel_i = '0;
    bus.s_ack_i = 1'b0;
    bus.s_err_i = 1'b0;
    bus.s_dat_i = '0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_timeout();
    test_ack_err_same();
    test_master_abort();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
